// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round counts, FSM states,
// the S-box, xtime and the byte/column slicing helpers (FIPS-197 byte order).
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;
    localparam logic [1:0] KEY_LEN_RSV = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_fsm_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte idx of a 128-bit state; byte 0 is bits [127:120].
    function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
        return s[127 - 8*idx -: 8];
    endfunction

    // Column c of a 128-bit state; column 0 is bits [127:96].
    function automatic logic [31:0] get_col(input logic [127:0] s, input int c);
        return s[127 - 32*c -: 32];
    endfunction

    // Round count for a key length; the reserved code falls back to AES-128.
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: return NR_128;
            KEY_LEN_192: return NR_192;
            KEY_LEN_256: return NR_256;
            default:     return NR_128;
        endcase
    endfunction

    function automatic logic is_rsv_len(input logic [1:0] key_len);
        return key_len == KEY_LEN_RSV;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round, purely combinational:
// SubBytes -> ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
#(
    parameter int RND_SIZE = 128,
    parameter int WRD_SIZE = 32,
    parameter int NUM_BLK  = 4
) (
    input  logic [RND_SIZE-1:0] state_in,
    input  logic [RND_SIZE-1:0] rk,
    input  logic                final_rnd,
    output logic [RND_SIZE-1:0] state_out
);

    localparam int ROWS = WRD_SIZE / 8;

    logic [RND_SIZE-1:0] sr;
    logic [RND_SIZE-1:0] mc;

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // SubBytes and ShiftRows together: row r of column c comes from column c+r.
    always_comb begin
        sr = '0;
        for (int c = 0; c < NUM_BLK; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                sr[RND_SIZE-1 - 8*(ROWS*c + r) -: 8] =
                    sbox(get_byte(state_in, ROWS*((c + r) % NUM_BLK) + r));
            end
        end
    end

    // MixColumns on every column of the shifted state.
    always_comb begin
        mc = '0;
        for (int c = 0; c < NUM_BLK; c++) begin
            mc[RND_SIZE-1 - WRD_SIZE*c -: WRD_SIZE] = mix_col(get_col(sr, c));
        end
    end

    assign state_out = (final_rnd ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryption: initial AddRoundKey on accept, then
// one round per clock through a single round datapath, round keys fetched
// by index from an external expanded-key store.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int RND_SIZE = 128,
    parameter int WRD_SIZE = 32,
    parameter int NUM_BLK  = 4,
    parameter int CNT_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [RND_SIZE-1:0] i_text,
    input  logic [1:0]          i_key_len,
    output logic [CNT_SIZE-1:0] o_rk_idx,
    input  logic [RND_SIZE-1:0] i_rk,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [RND_SIZE-1:0] o_cypher,
    output logic                o_key_err
);

    aes_fsm_e            fsm;
    logic [CNT_SIZE-1:0] cnt;
    logic [CNT_SIZE-1:0] nr_reg;
    logic [RND_SIZE-1:0] state_reg;
    logic                err_reg;
    logic [RND_SIZE-1:0] round_out;
    logic                last_rnd;
    logic                accept;

    assign last_rnd = (cnt == nr_reg);

    aes_round_comb #(
        .RND_SIZE (RND_SIZE),
        .WRD_SIZE (WRD_SIZE),
        .NUM_BLK  (NUM_BLK)
    ) u_round (
        .state_in  (state_reg),
        .rk        (i_rk),
        .final_rnd (last_rnd),
        .state_out (round_out)
    );

    // Outputs decode the registered state; only o_ready sees i_ready, in DONE.
    assign o_ready   = (fsm == ST_IDLE) || ((fsm == ST_DONE) && i_ready);
    assign o_valid   = (fsm == ST_DONE);
    assign o_rk_idx  = (fsm == ST_ROUND) ? cnt : '0;
    assign o_cypher  = (fsm == ST_DONE) ? state_reg : '0;
    assign o_key_err = err_reg && (fsm != ST_IDLE);
    assign accept    = i_valid && o_ready;

    // Sequencer: accept/rk0 whitening, NR rounds, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= ST_IDLE;
            cnt       <= '0;
            nr_reg    <= CNT_SIZE'(NR_128);
            state_reg <= '0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            // In IDLE and DONE the key store is addressed at index 0.
            state_reg <= i_text ^ i_rk;
            nr_reg    <= CNT_SIZE'(nr_of(i_key_len));
            err_reg   <= is_rsv_len(i_key_len);
            cnt       <= CNT_SIZE'(1);
            fsm       <= ST_ROUND;
        end else begin
            case (fsm)
                ST_ROUND: begin
                    state_reg <= round_out;
                    if (last_rnd) begin
                        fsm <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        fsm <= ST_IDLE;
                        cnt <= '0;
                    end
                end
                default: begin
                    fsm <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors, backpressure,
// back-to-back blocks, reserved key length and reset in mid-block.
module tb_aes_cipher_iter;

    logic         clk;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_text;
    logic [1:0]   i_key_len;
    logic [3:0]   o_rk_idx;
    logic [127:0] i_rk;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_cypher;
    logic         o_key_err;

    int total = 0;
    int bad   = 0;

    logic [127:0] rk_mem [16];

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0] KEY_C   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] TEXT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    // Bench key store: combinational read at the requested index.
    assign i_rk = rk_mem[o_rk_idx];

    aes_cipher_iter #(
        .RND_SIZE (128),
        .WRD_SIZE (32),
        .NUM_BLK  (4),
        .CNT_SIZE (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_text    (i_text),
        .i_key_len (i_key_len),
        .o_rk_idx  (o_rk_idx),
        .i_rk      (i_rk),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_cypher  (o_cypher),
        .o_key_err (o_key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = TB_SBOX[(255 - int'(w[8*i +: 8])) * 8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] tb_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Software key expansion; key is left-aligned in 256 bits, nk = 4/6/8.
    task automatic load_keys(input logic [255:0] key, input int nk);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = tb_xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_mem[r] = '0;
        end
    endtask

    // Steps until o_valid, bounded; an expired bound counts as a failure.
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!o_valid && n < limit) begin
            step();
            n++;
        end
        if (!o_valid) chk("valid_timeout", 128'd0, 128'd1);
    endtask

    // One block with i_ready high; inputs are scrambled while it is in flight.
    task automatic run_block(input string tag, input logic [127:0] text, input logic [1:0] len,
                             input logic [127:0] exp_ct, input logic exp_err, input int exp_n);
        int n;
        i_text    = text;
        i_key_len = len;
        i_valid   = 1'b1;
        step();
        i_valid   = 1'b0;
        i_text    = {$urandom, $urandom, $urandom, $urandom};
        i_key_len = 2'b10;
        wait_valid(20, n);
        chk({tag, "_lat"}, 128'(n), 128'(exp_n));
        chk({tag, "_ct"}, o_cypher, exp_ct);
        chk({tag, "_err"}, 128'(o_key_err), 128'(exp_err));
        step();
        chk({tag, "_vld_drop"}, 128'(o_valid), 128'd0);
    endtask

    initial begin
        int n;
        int nv;
        int t_v [2];
        logic seen_valid;

        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_text    = '0;
        i_key_len = 2'b00;
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;

        // Reset state
        step();
        step();
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_cypher", o_cypher, 128'd0);
        chk("rst_key_err", 128'(o_key_err), 128'd0);
        chk("rst_rk_idx", 128'(o_rk_idx), 128'd0);
        chk("rst_state", dut.state_reg, 128'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 128'(o_ready), 128'd1);

        // FIPS-197 Appendix B with intermediate checks
        load_keys({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        i_text    = 128'h3243f6a8885a308d313198a2e0370734;
        i_key_len = 2'b00;
        i_valid   = 1'b1;
        step();
        i_valid = 1'b0;
        chk("b_rk_idx1", 128'(o_rk_idx), 128'd1);
        chk("b_rk1", i_rk, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("b_ready_busy", 128'(o_ready), 128'd0);
        step();
        chk("b_state_e1", dut.state_reg, 128'ha49c7ff2689f352b6b5bea43026a5049);
        wait_valid(20, n);
        chk("b_lat", 128'(n + 1), 128'd10);
        chk("b_ct", o_cypher, 128'h3925841d02dc09fbdc118597196a0b32);
        step();
        chk("b_idle_ready", 128'(o_ready), 128'd1);

        // FIPS-197 Appendix C, all three key lengths
        load_keys(KEY_C, 4);
        run_block("c128", TEXT_C, 2'b00, CT_C128, 1'b0, 10);
        load_keys(KEY_C, 6);
        run_block("c192", TEXT_C, 2'b01, CT_C192, 1'b0, 12);
        load_keys(KEY_C, 8);
        run_block("c256", TEXT_C, 2'b10, CT_C256, 1'b0, 14);

        // Backpressure in DONE with a pending block
        load_keys(KEY_C, 4);
        i_ready   = 1'b0;
        i_text    = TEXT_C;
        i_key_len = 2'b00;
        i_valid   = 1'b1;
        step();
        wait_valid(20, n);
        chk("bp_lat", 128'(n), 128'd10);
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("bp_valid%0d", k), 128'(o_valid), 128'd1);
            chk($sformatf("bp_ready%0d", k), 128'(o_ready), 128'd0);
            chk($sformatf("bp_ct%0d", k), o_cypher, CT_C128);
        end
        i_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 128'(o_ready), 128'd1);
        step();
        i_valid = 1'b0;
        chk("bp_accept_vld", 128'(o_valid), 128'd0);
        chk("bp_accept_idx", 128'(o_rk_idx), 128'd1);
        wait_valid(20, n);
        chk("bp2_lat", 128'(n), 128'd10);
        chk("bp2_ct", o_cypher, CT_C128);
        step();

        // Back-to-back AES-128 blocks with i_ready held high
        i_text    = TEXT_C;
        i_key_len = 2'b00;
        i_valid   = 1'b1;
        step();
        nv = 0;
        t_v[0] = 0;
        t_v[1] = 0;
        for (int k = 1; k <= 30 && nv < 2; k++) begin
            step();
            if (o_valid) begin
                t_v[nv] = k;
                chk($sformatf("b2b_ct%0d", nv), o_cypher, CT_C128);
                nv++;
            end
        end
        i_valid = 1'b0;
        step();
        chk("b2b_count", 128'(nv), 128'd2);
        chk("b2b_first", 128'(t_v[0]), 128'd10);
        chk("b2b_space", 128'(t_v[1] - t_v[0]), 128'd11);
        chk("b2b_idle", 128'(o_valid), 128'd0);

        // Reserved key length, then a normal block clears the flag
        run_block("rsv", TEXT_C, 2'b11, CT_C128, 1'b1, 10);
        run_block("after_rsv", TEXT_C, 2'b00, CT_C128, 1'b0, 10);

        // Reset in round 5 discards the block
        i_text    = TEXT_C;
        i_key_len = 2'b00;
        i_valid   = 1'b1;
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid_cnt5", 128'(o_rk_idx), 128'd5);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 128'(o_valid), 128'd0);
        chk("mid_rst_cypher", o_cypher, 128'd0);
        chk("mid_rst_err", 128'(o_key_err), 128'd0);
        chk("mid_rst_idx", 128'(o_rk_idx), 128'd0);
        rst_n = 1'b1;
        step();
        chk("mid_ready", 128'(o_ready), 128'd1);
        seen_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (o_valid) seen_valid = 1'b1;
        end
        chk("mid_no_valid", 128'(seen_valid), 128'd0);
        run_block("fresh", TEXT_C, 2'b00, CT_C128, 1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
